alu: RTL and testbench

32-bit arithmetic/logic unit of the datapath. Each cycle it executes one operation selected by a 5-bit opcode in the top bits of `op_sel` on operands `A` and `B`. It produces a 64-bit result split into `Zhi` and `Zlo`, which feeds the Z register pair (HI/LO for multiply and divide). Both outputs are registered.

---
 rtl/alu.sv | 158 +++++++++++++++
 tb/tb_alu.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Single-cycle 32-bit ALU: add/sub (CLA), logic, shift/rotate, radix-4 Booth multiply, signed divide, neg/not.
// The 64-bit result {Zhi, Zlo} is registered; clear (active-low, async) zeroes it.
module alu (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] op_sel,
  output logic [31:0] Zhi,
  output logic [31:0] Zlo
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [4:0]  opcode;
  logic [4:0]  amt;
  logic        unused_bits;

  assign opcode      = op_sel[31:27];
  assign amt         = B[4:0];
  assign unused_bits = ^op_sel[26:0];

  // Carry-lookahead adder: 4-bit groups with group generate/propagate chained across groups.
  logic [31:0] add_b, g, p, c, sum;
  logic [6:0]  gg, gp;
  logic [7:0]  cg;
  logic [3:0]  gk, pk;

  always_comb begin
    add_b = (opcode == OP_SUB) ? ~B : B;
    g     = A & add_b;
    p     = A ^ add_b;
    gg    = '0;
    gp    = '0;
    cg    = '0;
    c     = '0;
    gk    = '0;
    pk    = '0;
    cg[0] = (opcode == OP_SUB);
    for (int k = 0; k < 7; k++) begin
      gk        = g[4*k +: 4];
      pk        = p[4*k +: 4];
      gp[k]     = &pk;
      gg[k]     = gk[3] | (pk[3] & gk[2]) | (pk[3] & pk[2] & gk[1]) | (pk[3] & pk[2] & pk[1] & gk[0]);
      cg[k+1]   = gg[k] | (gp[k] & cg[k]);
    end
    for (int k = 0; k < 8; k++) begin
      c[4*k] = cg[k];
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
    end
    sum = p ^ c;
  end

  // Radix-4 Booth: 16 digits in {-2..2}, each selecting a shifted/negated copy of A.
  logic [32:0]        bx;
  logic [2:0]         trip;
  logic signed [63:0] a_ext, pp, prod;

  always_comb begin
    bx    = {B, 1'b0};
    a_ext = {{32{A[31]}}, A};
    prod  = '0;
    pp    = '0;
    trip  = '0;
    for (int i = 0; i < 16; i++) begin
      trip = bx[2*i +: 3];
      case (trip)
        3'b001, 3'b010: pp = a_ext;
        3'b011:         pp = a_ext <<< 1;
        3'b100:         pp = -(a_ext <<< 1);
        3'b101, 3'b110: pp = -a_ext;
        default:        pp = '0;
      endcase
      prod = prod + (pp <<< (2*i));
    end
  end

  // Signed divide via magnitudes; the quotient takes the XOR of signs, the remainder follows A.
  logic [31:0] mag_a, mag_b, q_mag, r_mag, div_q, div_r;

  always_comb begin
    mag_a = A[31] ? (~A + 32'd1) : A;
    mag_b = B[31] ? (~B + 32'd1) : B;
    q_mag = '0;
    r_mag = '0;
    if (mag_b != 32'd0) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    div_q = (A[31] ^ B[31]) ? (~q_mag + 32'd1) : q_mag;
    div_r = A[31] ? (~r_mag + 32'd1) : r_mag;
  end

  logic [63:0] rot;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    rot    = '0;
    case (opcode)
      OP_ADD, OP_SUB: res_lo = sum;
      OP_AND:         res_lo = A & B;
      OP_OR:          res_lo = A | B;
      OP_SHR:         res_lo = A >> amt;
      OP_SHRA:        res_lo = $signed(A) >>> amt;
      OP_SHL:         res_lo = A << amt;
      OP_ROR: begin
        rot    = {A, A} >> amt;
        res_lo = rot[31:0];
      end
      OP_ROL: begin
        rot    = {A, A} << amt;
        res_lo = rot[63:32];
      end
      OP_MUL: {res_hi, res_lo} = prod;
      OP_DIV: begin
        if (B == 32'd0) begin
          res_hi = A;
          res_lo = 32'hFFFF_FFFF;
        end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          res_hi = '0;
          res_lo = 32'h8000_0000;
        end else begin
          res_hi = div_r;
          res_lo = div_q;
        end
      end
      OP_NEG:  res_lo = ~B + 32'd1;
      OP_NOT:  res_lo = ~B;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      Zhi <= '0;
      Zlo <= '0;
    end else begin
      Zhi <= res_hi;
      Zlo <= res_lo;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: reset behaviour, directed cases with fixed expectations, and random ops against a reference model.
module tb_alu;
  logic        clock;
  logic        clear;
  logic [31:0] A, B, op_sel;
  logic [31:0] Zhi, Zlo;

  int n_checks = 0;
  int n_fail   = 0;

  alu dut (
    .clock  (clock),
    .clear  (clear),
    .A      (A),
    .B      (B),
    .op_sel (op_sel),
    .Zhi    (Zhi),
    .Zlo    (Zlo)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [63:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb, q, r, prod;
    logic [31:0] x;
    logic [63:0] res;
    res = 64'd0;
    sa  = signed'(a);
    sb  = signed'(b);
    la  = longint'(sa);
    lb  = longint'(sb);
    case (op)
      5'd3:  res[31:0] = a + b;
      5'd4:  res[31:0] = a - b;
      5'd5:  res[31:0] = a & b;
      5'd6:  res[31:0] = a | b;
      5'd7:  res[31:0] = a >> b[4:0];
      5'd8:  res[31:0] = sa >>> b[4:0];
      5'd9:  res[31:0] = a << b[4:0];
      5'd10: begin
        x = a;
        for (int i = 0; i < int'(b[4:0]); i++) x = {x[0], x[31:1]};
        res[31:0] = x;
      end
      5'd11: begin
        x = a;
        for (int i = 0; i < int'(b[4:0]); i++) x = {x[30:0], x[31]};
        res[31:0] = x;
      end
      5'd15: begin
        prod = la * lb;
        res  = prod;
      end
      5'd16: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q   = la / lb;
          r   = la % lb;
          res = {r[31:0], q[31:0]};
        end
      end
      5'd17: res[31:0] = 32'd0 - b;
      5'd18: res[31:0] = ~b;
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    n_checks++;
    assert ({Zhi, Zlo} === {exp_hi, exp_lo})
    else begin
      n_fail++;
      $error("FAIL %s: got Zhi=%h Zlo=%h, expected Zhi=%h Zlo=%h", tag, Zhi, Zlo, exp_hi, exp_lo);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r      = $urandom();
    op_sel = {op, r[26:0]};
    A      = a;
    B      = b;
  endtask

  task automatic run(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    @(negedge clock);
    drive(op, a, b);
    @(posedge clock);
    #1;
    check(tag, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'd1;
      2:       v = 32'hFFFF_FFFF;
      3:       v = 32'h8000_0000;
      4:       v = 32'h7FFF_FFFF;
      5:       v = $urandom_range(0, 40);
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    logic [63:0] exp;
    logic [4:0]  op;
    logic [31:0] a, b;

    clear = 1'b0;
    drive(5'd3, 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(5'($urandom_range(0, 31)), $urandom(), $urandom());
      @(posedge clock);
      #1;
      check("reset_hold", 32'd0, 32'd0);
    end

    // Release between edges: nothing is captured until the following rising edge.
    @(negedge clock);
    clear = 1'b1;
    drive(5'd3, 32'd8960, 32'd6500);
    #1;
    check("after_release_no_edge", 32'd0, 32'd0);
    @(posedge clock);
    #1;
    check("add_first_capture", 32'd0, 32'd15460);

    run("sub",        5'd4,  32'd80000, 32'd10000000, 32'd0, 32'hFF68_A200);
    run("mul_small",  5'd15, 32'd960, 32'd60, 32'd0, 32'd57600);
    run("mul_neg",    5'd15, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run("mul_minmin", 5'd15, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
    run("div_pos",    5'd16, 32'd8, 32'd3, 32'd2, 32'd2);
    run("div_neg",    5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_zero",   5'd16, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF);
    run("div_ovf",    5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run("shr",        5'd7,  32'd8, 32'd2, 32'd0, 32'd2);
    run("shra_amt0",  5'd8,  32'd8, 32'h8000_0000, 32'd0, 32'd8);
    run("ror",        5'd10, 32'd8, 32'd1, 32'd0, 32'd4);
    run("rol_amt0",   5'd11, 32'd8, 32'h8000_0000, 32'd0, 32'd8);
    run("shra_sign",  5'd8,  32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000);
    run("rol_wrap",   5'd11, 32'h8000_0001, 32'd1, 32'd0, 32'd3);
    run("shl",        5'd9,  32'h8000_0003, 32'd33, 32'd0, 32'h0000_0006);
    run("and",        5'd5,  32'h00F0_0000, 32'h00F8_0000, 32'd0, 32'h00F0_0000);
    run("or",         5'd6,  32'hAAAA_AAAA, 32'h5555_5555, 32'd0, 32'hFFFF_FFFF);
    run("neg",        5'd17, 32'h1111_1111, 32'h00FF_00FF, 32'd0, 32'hFF00_FF01);
    run("not",        5'd18, 32'h1111_1111, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run("op_zero",    5'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
    run("op_illegal", 5'd31, 32'h1234_5678, 32'h0000_0001, 32'd0, 32'd0);

    // Asynchronous clear mid-cycle, held across an edge, then released.
    run("pre_async",  5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
    #2;
    clear = 1'b0;
    #1;
    check("async_clear", 32'd0, 32'd0);
    @(posedge clock);
    #1;
    check("clear_held", 32'd0, 32'd0);
    @(negedge clock);
    clear = 1'b1;

    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) op = 5'($urandom_range(3, 18));
      a = pick();
      b = pick();
      exp = model(op, a, b);
      run($sformatf("rand%0d_op%0d", i, op), op, a, b, exp[63:32], exp[31:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
